// File: rtl/instr_stream_mem.sv
// instr_stream_mem: boot-time instruction store loaded over a framed
// byte stream. Bytes between START_TOK and END_TOK are packed into
// DATA_W-bit words and written at consecutive addresses. ESC_TOK makes
// the byte after it plain data, so any byte value can be loaded. Fetch
// reads are combinational and return zero beyond the loaded word count.
//
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   byte_valid_i, byte_i  stream byte in; byte_ready_o high out of reset
//   addr_i                fetch byte address
//   instr_o, misalign_o   word at addr_i, addr_i not word-aligned
//   loading_o             frame in progress
//   load_done_o           one-cycle pulse after a frame-ending END_TOK
//   word_count_o          words committed by the current/last frame
//   err_overflow_o        sticky: frame held more than DEPTH words
//   err_partial_o         sticky: frame ended mid-word
module instr_stream_mem #(
  parameter int          DATA_W     = 32,
  parameter int          DEPTH      = 64,
  parameter int          ADDR_W     = 32,
  parameter logic [7:0]  START_TOK  = 8'hFE,
  parameter logic [7:0]  END_TOK    = 8'hFF,
  parameter logic [7:0]  ESC_TOK    = 8'hFD,
  parameter bit          BIG_ENDIAN = 1'b1,
  localparam int         BPW        = DATA_W / 8,
  localparam int         IDX_W      = $clog2(BPW),
  localparam int         CNT_W      = $clog2(DEPTH + 1),
  localparam int         MEM_AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  output logic              byte_ready_o,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0] instr_o,
  output logic              misalign_o,
  output logic              loading_o,
  output logic              load_done_o,
  output logic [CNT_W-1:0]  word_count_o,
  output logic              err_overflow_o,
  output logic              err_partial_o
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ESC} state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   bidx_q, bidx_d;
  logic [DATA_W-1:0]  asm_q, asm_d;
  logic               ovf_q, ovf_d;
  logic               part_q, part_d;
  logic               done_q, done_d;

  logic [DATA_W-1:0]  mem [DEPTH];

  logic               take, is_data, do_commit, clear, mem_we;
  logic [DATA_W-1:0]  merged, commit_w;
  int                 slot;

  assign take         = byte_valid_i && reset;
  assign byte_ready_o = reset;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bidx_d    = bidx_q;
    asm_d     = asm_q;
    ovf_d     = ovf_q;
    part_d    = part_q;
    done_d    = 1'b0;
    is_data   = 1'b0;
    do_commit = 1'b0;
    clear     = 1'b0;
    mem_we    = 1'b0;
    commit_w  = asm_q;
    // slot 0 is the first byte of the word in stream order
    slot      = BIG_ENDIAN ? (BPW - 1 - int'(bidx_q)) : int'(bidx_q);
    merged    = asm_q;
    merged[slot*8 +: 8] = byte_i;

    case (state_q)
      S_IDLE: begin
        if (take && byte_i == START_TOK) begin
          clear   = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (take) begin
          if (byte_i == START_TOK) begin
            clear = 1'b1;
          end else if (byte_i == END_TOK) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            if (bidx_q != '0) begin
              // unfilled slots of asm_q are still zero
              part_d    = 1'b1;
              do_commit = 1'b1;
              bidx_d    = '0;
              asm_d     = '0;
            end
          end else if (byte_i == ESC_TOK) begin
            state_d = S_ESC;
          end else begin
            is_data = 1'b1;
          end
        end
      end
      S_ESC: begin
        if (take) begin
          is_data = 1'b1;
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // once overflowed, data is dropped and the byte index stays at 0
    if (is_data && !ovf_q) begin
      if (bidx_q == LAST_IDX) begin
        do_commit = 1'b1;
        commit_w  = merged;
        bidx_d    = '0;
        asm_d     = '0;
      end else begin
        asm_d  = merged;
        bidx_d = bidx_q + 1'b1;
      end
    end

    if (do_commit) begin
      if (cnt_q == CNT_W'(DEPTH)) begin
        ovf_d = 1'b1;
      end else begin
        mem_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
      end
    end

    if (clear) begin
      cnt_d  = '0;
      bidx_d = '0;
      asm_d  = '0;
      ovf_d  = 1'b0;
      part_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bidx_q  <= '0;
      asm_q   <= '0;
      ovf_q   <= 1'b0;
      part_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bidx_q  <= bidx_d;
      asm_q   <= asm_d;
      ovf_q   <= ovf_d;
      part_q  <= part_d;
      done_q  <= done_d;
    end
  end

  // storage is not reset; word_count alone marks which entries are valid
  always_ff @(posedge clk) begin
    if (mem_we) mem[cnt_q[MEM_AW-1:0]] <= commit_w;
  end

  logic [ADDR_W:0] rd_idx;
  assign rd_idx     = {1'b0, addr_i} >> IDX_W;
  assign instr_o    = (rd_idx < (ADDR_W+1)'(cnt_q)) ? mem[rd_idx[MEM_AW-1:0]] : '0;
  assign misalign_o = |addr_i[IDX_W-1:0];

  assign loading_o      = (state_q != S_IDLE);
  assign load_done_o    = done_q;
  assign word_count_o   = cnt_q;
  assign err_overflow_o = ovf_q;
  assign err_partial_o  = part_q;

endmodule

// File: tb/tb_instr_stream_mem.sv
module tb_instr_stream_mem;
  localparam int D   = 4;
  localparam int BPW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bvalid;
  logic [7:0]  bdata;
  logic [31:0] addr;

  logic        rdy_be, rdy_le, mis_be, mis_le, ld_be, ld_le, done_be, done_le;
  logic        ovf_be, ovf_le, part_be, part_le;
  logic [31:0] ins_be, ins_le;
  logic [2:0]  cnt_be, cnt_le;

  int errs = 0;
  int checks = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  instr_stream_mem #(.DATA_W(32), .DEPTH(D), .ADDR_W(32), .BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .reset(rst_n), .byte_valid_i(bvalid), .byte_i(bdata), .byte_ready_o(rdy_be),
    .addr_i(addr), .instr_o(ins_be), .misalign_o(mis_be), .loading_o(ld_be),
    .load_done_o(done_be), .word_count_o(cnt_be), .err_overflow_o(ovf_be), .err_partial_o(part_be));

  instr_stream_mem #(.DATA_W(32), .DEPTH(D), .ADDR_W(32), .BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .reset(rst_n), .byte_valid_i(bvalid), .byte_i(bdata), .byte_ready_o(rdy_le),
    .addr_i(addr), .instr_o(ins_le), .misalign_o(mis_le), .loading_o(ld_le),
    .load_done_o(done_le), .word_count_o(cnt_le), .err_overflow_o(ovf_le), .err_partial_o(part_le));

  always @(negedge clk) if (done_be === 1'b1) done_cnt++;

  // ---- reference model: data bytes of the current/last frame ----
  logic [7:0] q[$];
  bit in_frame = 0, in_esc = 0, exp_done = 0;

  function automatic void model_reset();
    q.delete(); in_frame = 0; in_esc = 0; exp_done = 0;
  endfunction

  function automatic void model_feed(logic [7:0] b);
    if (!in_frame) begin
      if (b == 8'hFE) begin q.delete(); in_frame = 1; end
    end else if (in_esc) begin
      q.push_back(b); in_esc = 0;
    end else if (b == 8'hFE) q.delete();
    else if (b == 8'hFF) begin in_frame = 0; exp_done = 1; end
    else if (b == 8'hFD) in_esc = 1;
    else q.push_back(b);
  endfunction

  function automatic int exp_cnt();
    int n = q.size();
    int w = in_frame ? n / BPW : (n + BPW - 1) / BPW;
    return (w > D) ? D : w;
  endfunction

  function automatic bit exp_ovf();
    int n = q.size();
    return in_frame ? (n >= (D + 1) * BPW) : (n > D * BPW);
  endfunction

  function automatic bit exp_part();
    int n = q.size();
    return !in_frame && (n % BPW != 0) && (n < (D + 1) * BPW);
  endfunction

  function automatic logic [31:0] exp_word(int k, bit be);
    logic [31:0] w = '0;
    logic [7:0]  b;
    if (k >= exp_cnt()) return '0;
    for (int j = 0; j < BPW; j++) begin
      b = (k * BPW + j < q.size()) ? q[k * BPW + j] : 8'h00;
      if (be) w[31 - 8*j -: 8] = b; else w[8*j +: 8] = b;
    end
    return w;
  endfunction

  // ---- stimulus ----
  task automatic drive(input logic v, input logic [7:0] b);
    bvalid = v; bdata = b;
    exp_done = 0;
    @(posedge clk); #1;
    if (v && rst_n) model_feed(b);
    bvalid = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic feed(input logic [7:0] s[$]);
    foreach (s[i]) drive(1'b1, s[i]);
  endtask

  task automatic test_reset();
    bvalid = 1'b1; bdata = 8'hFE; addr = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rdy_be !== 1'b0) begin errs++; $display("FAIL reset_ready: got %b want 0", rdy_be); end
    checks++; if (ld_be !== 1'b0) begin errs++; $display("FAIL reset_loading: got %b want 0", ld_be); end
    bvalid = 1'b0;
    model_reset();
    rst_n = 1'b1; #1;
    checks++; if (rdy_be !== 1'b1) begin errs++; $display("FAIL reset_ready_out: got %b want 1", rdy_be); end
    checks++; if (cnt_be !== 3'd0) begin errs++; $display("FAIL reset_count: got %0d want 0", cnt_be); end
    checks++; if ({done_be, ovf_be, part_be} !== 3'b000) begin errs++; $display("FAIL reset_flags: got %b want 000", {done_be, ovf_be, part_be}); end
    for (int a = 0; a < 24; a += 4) begin
      addr = a; #1;
      checks++; if (ins_be !== 32'h0) begin errs++; $display("FAIL reset_read@%0d: got %h want 0", a, ins_be); end
    end
  endtask

  task automatic test_basic();
    logic [7:0] s[$];
    int d0 = done_cnt;
    s = '{8'hFE, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'hFF};
    feed(s);
    @(posedge clk); #1;
    checks++; if (done_cnt - d0 !== 1) begin errs++; $display("FAIL basic_done_pulses: got %0d want 1", done_cnt - d0); end
    checks++; if (cnt_be !== 3'd2) begin errs++; $display("FAIL basic_count: got %0d want 2", cnt_be); end
    addr = 0; #1;
    checks++; if (ins_be !== 32'h12345678) begin errs++; $display("FAIL basic_mem0: got %h want 12345678", ins_be); end
    checks++; if (ins_le !== 32'h78563412) begin errs++; $display("FAIL basic_mem0_le: got %h want 78563412", ins_le); end
    addr = 4; #1;
    checks++; if (ins_be !== 32'h9ABCDEF0) begin errs++; $display("FAIL basic_mem1: got %h want 9abcdef0", ins_be); end
    checks++; if (mis_be !== 1'b0) begin errs++; $display("FAIL basic_aligned: got %b want 0", mis_be); end
    addr = 5; #1;
    checks++; if (mis_be !== 1'b1 || ins_be !== 32'h9ABCDEF0) begin errs++; $display("FAIL basic_misalign: got %b/%h want 1/9abcdef0", mis_be, ins_be); end
    addr = 8; #1;
    checks++; if (ins_be !== 32'h0) begin errs++; $display("FAIL basic_unwritten: got %h want 0", ins_be); end
    checks++; if ({ld_be, ovf_be, part_be} !== 3'b000) begin errs++; $display("FAIL basic_status: got %b want 000", {ld_be, ovf_be, part_be}); end
  endtask

  task automatic test_escape();
    logic [7:0] s[$];
    int d0 = done_cnt;
    s = '{8'hFE, 8'hFD, 8'hFF, 8'hFD, 8'hFE, 8'hFD, 8'hFD, 8'h01, 8'hFF};
    feed(s);
    addr = 0; #1;
    checks++; if (ins_be !== 32'hFFFEFD01) begin errs++; $display("FAIL esc_mem0: got %h want fffefd01", ins_be); end
    checks++; if ({cnt_be, ovf_be, part_be} !== {3'd1, 2'b00}) begin errs++; $display("FAIL esc_status: got %0d/%b%b want 1/00", cnt_be, ovf_be, part_be); end
    @(posedge clk); #1;
    checks++; if (done_cnt - d0 !== 1) begin errs++; $display("FAIL esc_done_pulses: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_partial();
    logic [7:0] s[$];
    s = '{8'hFE, 8'hAA, 8'hBB, 8'hFF};
    feed(s);
    addr = 0; #1;
    checks++; if (ins_le !== 32'h0000BBAA) begin errs++; $display("FAIL partial_le: got %h want 0000bbaa", ins_le); end
    checks++; if (ins_be !== 32'hAABB0000) begin errs++; $display("FAIL partial_be: got %h want aabb0000", ins_be); end
    checks++; if ({cnt_le, part_le, ovf_le} !== {3'd1, 2'b10}) begin errs++; $display("FAIL partial_status: got %0d/%b%b want 1/10", cnt_le, part_le, ovf_le); end
  endtask

  task automatic test_overflow();
    logic [7:0] s[$];
    s.push_back(8'hFE);
    for (int i = 0; i < 20; i++) s.push_back(8'(8'h10 + i));
    s.push_back(8'hFF);
    feed(s);
    checks++; if ({cnt_be, ovf_be, part_be} !== {3'd4, 2'b10}) begin errs++; $display("FAIL ovf_status: got %0d/%b%b want 4/10", cnt_be, ovf_be, part_be); end
    addr = 0; #1;
    checks++; if (ins_be !== 32'h10111213) begin errs++; $display("FAIL ovf_mem0: got %h want 10111213", ins_be); end
    addr = 12; #1;
    checks++; if (ins_be !== 32'h1C1D1E1F) begin errs++; $display("FAIL ovf_mem3: got %h want 1c1d1e1f", ins_be); end
    addr = 16; #1;
    checks++; if (ins_be !== 32'h0) begin errs++; $display("FAIL ovf_beyond: got %h want 0", ins_be); end
    drive(1'b1, 8'hFE);
    checks++; if ({ovf_be, cnt_be, ld_be} !== {1'b0, 3'd0, 1'b1}) begin errs++; $display("FAIL ovf_clear: got %b/%0d/%b want 0/0/1", ovf_be, cnt_be, ld_be); end
    drive(1'b1, 8'hFF);
  endtask

  task automatic test_reset_midframe();
    logic [7:0] s[$];
    int d0;
    s = '{8'hFE, 8'h11, 8'h22};
    feed(s);
    do_reset(1);
    d0 = done_cnt;
    s = '{8'h33, 8'h44, 8'hFF};
    feed(s);
    @(posedge clk); #1;
    checks++; if (cnt_be !== 3'd0) begin errs++; $display("FAIL rstmid_count: got %0d want 0", cnt_be); end
    checks++; if (done_cnt - d0 !== 0) begin errs++; $display("FAIL rstmid_done: got %0d want 0", done_cnt - d0); end
    addr = 0; #1;
    checks++; if (ins_be !== 32'h0) begin errs++; $display("FAIL rstmid_read: got %h want 0", ins_be); end
    addr = 2; #1;
    checks++; if (mis_be !== 1'b1) begin errs++; $display("FAIL rstmid_misalign: got %b want 1", mis_be); end
  endtask

  task automatic test_restart();
    logic [7:0] s[$];
    s = '{8'hFE, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFE, 8'h05, 8'h06, 8'h07, 8'h08, 8'hFF};
    feed(s);
    addr = 0; #1;
    checks++; if (cnt_be !== 3'd1 || ins_be !== 32'h05060708) begin errs++; $display("FAIL restart: got %0d/%h want 1/05060708", cnt_be, ins_be); end
  endtask

  // idle cycles carrying END_TOK must not disturb a pending escape
  task automatic test_valid_gap();
    drive(1'b1, 8'hFE);
    drive(1'b1, 8'hFD);
    repeat (3) drive(1'b0, 8'hFF);
    checks++; if (ld_be !== 1'b1) begin errs++; $display("FAIL gap_loading: got %b want 1", ld_be); end
    drive(1'b1, 8'hFF); drive(1'b1, 8'h01); drive(1'b1, 8'h02); drive(1'b1, 8'h03);
    drive(1'b1, 8'hFF);
    addr = 0; #1;
    checks++; if (ins_be !== 32'hFF010203) begin errs++; $display("FAIL gap_mem0: got %h want ff010203", ins_be); end
  endtask

  task automatic test_random(input int steps, input int tokpct);
    logic [7:0] b;
    int a;
    for (int i = 0; i < steps; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset(1);
      else begin
        if ($urandom_range(0, 99) < tokpct) b = 8'hFD + 8'($urandom_range(0, 2));
        else b = 8'($urandom_range(0, 255));
        drive($urandom_range(0, 3) != 0, b);
      end
      a = $urandom_range(0, 4 * D + 7);
      addr = a; #1;
      checks++; if (cnt_be !== 3'(exp_cnt())) begin errs++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, cnt_be, exp_cnt()); end
      checks++; if ({ld_be, done_be} !== {in_frame, exp_done}) begin errs++; $display("FAIL rnd_ld_done[%0d]: got %b want %b", i, {ld_be, done_be}, {in_frame, exp_done}); end
      checks++; if ({ovf_be, part_be} !== {exp_ovf(), exp_part()}) begin errs++; $display("FAIL rnd_err[%0d]: got %b want %b", i, {ovf_be, part_be}, {exp_ovf(), exp_part()}); end
      checks++; if (ins_be !== exp_word(a / 4, 1'b1)) begin errs++; $display("FAIL rnd_be@%0d[%0d]: got %h want %h", a, i, ins_be, exp_word(a / 4, 1'b1)); end
      checks++; if (ins_le !== exp_word(a / 4, 1'b0)) begin errs++; $display("FAIL rnd_le@%0d[%0d]: got %h want %h", a, i, ins_le, exp_word(a / 4, 1'b0)); end
      checks++; if (mis_be !== (a % 4 != 0)) begin errs++; $display("FAIL rnd_misalign@%0d: got %b want %b", a, mis_be, a % 4 != 0); end
    end
  endtask

  initial begin
    bvalid = 1'b0; bdata = 8'h00; addr = 0; rst_n = 1'b0;
    test_reset();
    test_basic();
    test_escape();
    test_partial();
    test_overflow();
    test_reset_midframe();
    test_restart();
    test_valid_gap();
    test_random(600, 30);
    test_random(1500, 3);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/instr_stream_mem.md
# instr_stream_mem

Parametrised instruction memory loaded over a byte-serial stream, the next generation of the core's boot-time instruction store. It sits between the host/UART byte link and the fetch stage. It reassembles framed bytes into words of configurable width and depth, with a selectable byte order and an escape mechanism so any byte value can be loaded. It serves combinational word reads to fetch, and reports load completion, word count and error status.

## Interface
- DATA_W, 32, instruction word width; multiple of 8, at least 16
- DEPTH, 64, number of words
- ADDR_W, 32, width of byte address from fetch
- START_TOK, 8'hFE, frame start byte
- END_TOK, 8'hFF, frame end byte
- ESC_TOK, 8'hFD, escape prefix; the next byte is taken as literal data
- BIG_ENDIAN, 1, 1: first byte of a word goes to bits [DATA_W-1:DATA_W-8]; 0: first byte goes to bits [7:0]

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low
- byte_valid_i  in  1  byte_i is valid this cycle
- byte_i  in  8  stream byte
- byte_ready_o  out  1  block accepts a byte this cycle
- addr_i  in  ADDR_W  fetch byte address
- instr_o  out  DATA_W  word at addr_i
- misalign_o  out  1  addr_i is not word-aligned
- loading_o  out  1  a frame is in progress
- load_done_o  out  1  one-cycle pulse at end of frame
- word_count_o  out  clog2(DEPTH+1)  number of words committed
- err_overflow_o  out  1  sticky: frame exceeded DEPTH words
- err_partial_o  out  1  sticky: frame ended mid-word

## Operation
- BPW = DATA_W/8. A byte is accepted when byte_valid_i && byte_ready_o.
- byte_ready_o = 1 whenever reset is deasserted; 0 while reset is asserted.
- FSM states:
  - IDLE: only START_TOK is acted on; all other accepted bytes are discarded. START_TOK -> LOAD, and clears word_count, byte index, assembly register and both error flags.
  - LOAD: START_TOK restarts the frame with the same clears and stays in LOAD. END_TOK -> IDLE. ESC_TOK -> ESC. Any other byte is data.
  - ESC: the next accepted byte, whatever its value, is data -> LOAD.
- Data byte handling:
  - The byte is placed at slot byte index, using the order set by BIG_ENDIAN; byte index then increments.
  - When byte index = BPW-1, the completed word (including this byte) is written to mem[word_count], word_count increments and byte index returns to 0.
  - If word_count = DEPTH at commit time, the write is suppressed, err_overflow_o is set and word_count holds. Further data is discarded until END_TOK or START_TOK.
- END_TOK with byte index != 0: the partial word is committed with unfilled slots zero, subject to the overflow rule. err_partial_o is set.
- ESC then END_TOK or START_TOK: that byte is loaded as data; framing is not affected.
- Read path: idx = addr_i >> log2(BPW). instr_o = mem[idx] if idx < word_count, else 0. This covers unwritten and out-of-range addresses.
- misalign_o = |addr_i[log2(BPW)-1:0]. On a misaligned address, instr_o still returns the word selected by idx.
- Memory array is not reset; validity is tracked only by word_count.
- loading_o = (state != IDLE).

## Timing
- Reset (reset=0 at an edge): state IDLE, word_count_o 0, load_done_o 0, loading_o 0, both error flags 0, byte index 0. instr_o reads 0 for every address, because word_count is 0.
- Reset mid-frame aborts the frame; the partial word is lost.
- A commit on edge N is visible on instr_o and word_count_o after edge N; reads have zero-cycle latency.
- load_done_o is high for exactly the one cycle after the edge that accepted END_TOK in LOAD. It does not fire for END_TOK received in IDLE or consumed in ESC.
- Error flags are set at the same edge as the offending event and held until the next START_TOK or reset.
- A word being assembled is never visible on instr_o before its commit.
- byte_valid_i = 0 leaves all state unchanged, including ESC.

## Test plan
- DATA_W=32, BIG_ENDIAN=1: stream FE 12 34 56 78 9A BC DE F0 FF -> mem[0]=0x12345678, mem[1]=0x9ABCDEF0, word_count=2, load_done_o pulses once. addr_i=4 -> 0x9ABCDEF0. addr_i=8 -> 0.
- Escape: FE FD FF FD FE FD FD 01 FF -> mem[0]=0xFFFEFD01, no error flags.
- Partial word, BIG_ENDIAN=0: FE AA BB FF -> mem[0]=0x0000BBAA, err_partial_o=1, word_count=1.
- Overflow, DEPTH=4: FE followed by 20 data bytes, then FF -> word_count=4, mem[0..3] hold the first 16 bytes, err_overflow_o=1. A new FE clears the flag.
- Reset mid-frame: FE 11 22, then reset=0 for 1 cycle, then 33 44 FF -> word_count=0, no load_done_o pulse, instr_o=0 at addr 0, misalign_o=1 at addr_i=2.
- Restart: FE 01 02 03 04 FE 05 06 07 08 FF -> word_count=1, mem[0]=0x05060708.
